// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM state
// encoding, opcode values, opcode classes and the datapath select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_LOAD    = 4'd0,
        CLS_STORE   = 4'd1,
        CLS_OP      = 4'd2,
        CLS_OPIMM   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd10
    } op_class_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PCSEL_PLUS4  = 2'd0;
    localparam logic [1:0] PCSEL_TARGET = 2'd1;
    localparam logic [1:0] PCSEL_ALU    = 2'd2;
    localparam logic [1:0] PCSEL_RESET  = 2'd3;

    localparam logic [1:0] WBSEL_ALU   = 2'd0;
    localparam logic [1:0] WBSEL_MEM   = 2'd1;
    localparam logic [1:0] WBSEL_PC4   = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_FUNCT = 2'd1;
    localparam logic [1:0] ALUOP_CMP   = 2'd2;
    localparam logic [1:0] ALUOP_PASSB = 2'd3;

    localparam logic [1:0] IR_CLEAR = 2'b10;
    localparam logic [1:0] IR_LOAD  = 2'b01;

endpackage

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational opcode decoder: maps the 7-bit major opcode to a class
// and flags whether the opcode is one the core implements.
module opcode_classifier
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       legal
);

    // Decode the major opcode into its class; unknown opcodes are illegal
    always_comb begin
        legal = 1'b1;
        case (opcode)
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OP:     cls = CLS_OP;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default: begin
                cls   = CLS_ILLEGAL;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback over a single shared memory port, counts
// retired instructions and halts on SYSTEM or an unknown opcode.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [1:0]       ir_control,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // The datapath loads PC_RESET directly; instruction fetch needs it word aligned.
    if (PC_RESET[1:0] != 2'b00) begin : g_pc_reset_align
        $error("PC_RESET must be word aligned");
    end

    state_t    state, state_n;
    op_class_t cls;
    logic      legal;
    logic      retire;

    opcode_classifier u_classifier (
        .opcode (opcode),
        .cls    (cls),
        .legal  (legal)
    );

    // Next-state and Moore/Mealy output decode; everything defaults to idle
    always_comb begin
        state_n      = state;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_control   = 2'b00;
        pc_we        = 1'b0;
        pc_sel       = PCSEL_PLUS4;
        rf_we        = 1'b0;
        wb_sel       = WBSEL_ALU;
        alu_op       = ALUOP_ADD;
        case (state)
            S_INIT: begin
                ir_control = IR_CLEAR;
                pc_we      = 1'b1;
                pc_sel     = PCSEL_RESET;
                state_n    = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_control = IR_LOAD;
                    state_n    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal || cls == CLS_SYSTEM) state_n = S_HALT;
                else                             state_n = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (cls)
                    CLS_OP, CLS_OPIMM: begin
                        alu_op  = ALUOP_FUNCT;
                        state_n = S_WRITEBACK;
                    end
                    CLS_LUI: begin
                        alu_op  = ALUOP_PASSB;
                        state_n = S_WRITEBACK;
                    end
                    CLS_BRANCH: begin
                        alu_op  = ALUOP_CMP;
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PCSEL_TARGET : PCSEL_PLUS4;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_n = S_MEM;
                    default:             state_n = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_n = S_FETCH;
                case (cls)
                    CLS_LOAD: wb_sel = WBSEL_MEM;
                    CLS_JAL: begin
                        wb_sel = WBSEL_PC4;
                        pc_sel = PCSEL_TARGET;
                    end
                    CLS_JALR: begin
                        wb_sel = WBSEL_PC4;
                        pc_sel = PCSEL_ALU;
                    end
                    default: ;
                endcase
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_INIT;
        endcase
    end

    // State, sticky halt flags and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_INIT;
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) begin
                if (!legal)                 illegal <= 1'b1;
                else if (cls == CLS_SYSTEM) halted  <= 1'b1;
            end
            if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle against hand-derived control values.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, pc_we, rf_we, halted, illegal;
    logic [1:0]  ir_control, pc_sel, wb_sel, alu_op;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.PC_RESET(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_control(ir_control), .pc_we(pc_we),
        .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release it while the FSM sits in INIT
    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'b0110011;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {halted, illegal}); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL init_mem_req got=%b exp=0", mem_req); end
        checks++; if (ir_control !== 2'b10) begin errors++; $display("FAIL init_ir got=%b exp=10", ir_control); end
        checks++; if ({pc_we, pc_sel} !== 3'b111) begin errors++; $display("FAIL init_pc got=%b exp=111", {pc_we, pc_sel}); end
    endtask

    // ADD with zero-wait memory: INIT, FETCH, DECODE, EXECUTE, WRITEBACK
    task automatic test_add();
        opcode = 7'b0110011; mem_ready = 1'b1;
        tick(); // FETCH
        checks++; if ({mem_req, mem_addr_sel, mem_we} !== 3'b100) begin errors++; $display("FAIL add_fetch_req got=%b exp=100", {mem_req, mem_addr_sel, mem_we}); end
        checks++; if (ir_control !== 2'b01) begin errors++; $display("FAIL add_fetch_ir got=%b exp=01", ir_control); end
        tick(); // DECODE
        checks++; if ({mem_req, ir_control, pc_we, rf_we} !== 5'b00000) begin errors++; $display("FAIL add_decode got=%b exp=00000", {mem_req, ir_control, pc_we, rf_we}); end
        tick(); // EXECUTE
        checks++; if ({alu_op, pc_we, rf_we} !== 4'b0100) begin errors++; $display("FAIL add_exec got=%b exp=0100", {alu_op, pc_we, rf_we}); end
        tick(); // WRITEBACK
        checks++; if ({rf_we, pc_we, pc_sel, wb_sel} !== 6'b110000) begin errors++; $display("FAIL add_wb got=%b exp=110000", {rf_we, pc_we, pc_sel, wb_sel}); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL add_retired_pre got=%0d exp=0", retired); end
        tick(); // FETCH
        checks++; if (retired !== 32'd1) begin errors++; $display("FAIL add_retired got=%0d exp=1", retired); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL add_refetch got=%b exp=1", mem_req); end
    endtask

    // LW with 3 fetch wait cycles and 2 memory wait cycles: 10 cycles in total
    task automatic test_lw();
        opcode = 7'b0000011; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_req, mem_addr_sel, ir_control} !== 4'b1000) begin errors++; $display("FAIL lw_fetch_wait%0d got=%b exp=1000", i, {mem_req, mem_addr_sel, ir_control}); end
            tick();
        end
        mem_ready = 1'b1; #1;
        checks++; if ({mem_req, mem_addr_sel, ir_control} !== 4'b1001) begin errors++; $display("FAIL lw_fetch_ready got=%b exp=1001", {mem_req, mem_addr_sel, ir_control}); end
        tick(); // DECODE
        tick(); // EXECUTE
        checks++; if ({alu_op, mem_req} !== 3'b000) begin errors++; $display("FAIL lw_exec got=%b exp=000", {alu_op, mem_req}); end
        mem_ready = 1'b0;
        tick(); // MEM
        for (int i = 0; i < 2; i++) begin
            checks++; if ({mem_req, mem_addr_sel, mem_we, pc_we} !== 4'b1100) begin errors++; $display("FAIL lw_mem_wait%0d got=%b exp=1100", i, {mem_req, mem_addr_sel, mem_we, pc_we}); end
            tick();
        end
        mem_ready = 1'b1; #1;
        checks++; if ({mem_req, mem_addr_sel, mem_we, pc_we, rf_we} !== 5'b11000) begin errors++; $display("FAIL lw_mem_ready got=%b exp=11000", {mem_req, mem_addr_sel, mem_we, pc_we, rf_we}); end
        tick(); // WRITEBACK (cycle 10)
        checks++; if ({rf_we, wb_sel, pc_sel, mem_we} !== 6'b101000) begin errors++; $display("FAIL lw_wb got=%b exp=101000", {rf_we, wb_sel, pc_sel, mem_we}); end
        tick(); // FETCH
        checks++; if (retired !== 32'd2) begin errors++; $display("FAIL lw_retired got=%0d exp=2", retired); end
    endtask

    // BEQ taken then BEQ not taken: 3 cycles each, no writeback
    task automatic test_branch();
        logic [1:0] exp_sel;
        opcode = 7'b1100011; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            branch_taken = (i == 0);
            exp_sel = (i == 0) ? 2'd1 : 2'd0;
            tick(); // DECODE
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL br%0d_decode_rf got=%b exp=0", i, rf_we); end
            tick(); // EXECUTE
            checks++; if ({alu_op, pc_we, pc_sel, rf_we} !== {2'd2, 1'b1, exp_sel, 1'b0}) begin errors++; $display("FAIL br%0d_exec got=%b exp=%b", i, {alu_op, pc_we, pc_sel, rf_we}, {2'd2, 1'b1, exp_sel, 1'b0}); end
            tick(); // FETCH again
            checks++; if ({mem_req, rf_we} !== 2'b10) begin errors++; $display("FAIL br%0d_next got=%b exp=10", i, {mem_req, rf_we}); end
            checks++; if (retired !== 32'd3 + i) begin errors++; $display("FAIL br%0d_retired got=%0d exp=%0d", i, retired, 3 + i); end
        end
    endtask

    // SW with one memory wait cycle, PC+4 on ready
    task automatic test_sw();
        opcode = 7'b0100011; mem_ready = 1'b1;
        tick(); // DECODE
        tick(); // EXECUTE
        checks++; if (alu_op !== 2'd0) begin errors++; $display("FAIL sw_exec got=%0d exp=0", alu_op); end
        mem_ready = 1'b0;
        tick(); // MEM waiting
        checks++; if ({mem_req, mem_we, mem_addr_sel, rf_we, pc_we} !== 5'b11100) begin errors++; $display("FAIL sw_mem_wait got=%b exp=11100", {mem_req, mem_we, mem_addr_sel, rf_we, pc_we}); end
        mem_ready = 1'b1; #1;
        checks++; if ({mem_we, rf_we, pc_we, pc_sel} !== 5'b10100) begin errors++; $display("FAIL sw_mem_ready got=%b exp=10100", {mem_we, rf_we, pc_we, pc_sel}); end
        tick(); // FETCH
        checks++; if ({mem_req, mem_we, retired} !== {2'b10, 32'd5}) begin errors++; $display("FAIL sw_next got=%b/%0d exp=10/5", {mem_req, mem_we}, retired); end
    endtask

    // LUI and JAL writeback selects
    task automatic test_lui_jal();
        opcode = 7'b0110111; mem_ready = 1'b1;
        tick(); tick(); // EXECUTE
        checks++; if (alu_op !== 2'd3) begin errors++; $display("FAIL lui_exec got=%0d exp=3", alu_op); end
        tick(); tick(); // WB, FETCH
        opcode = 7'b1101111;
        tick(); tick(); tick(); // WRITEBACK
        checks++; if ({rf_we, wb_sel, pc_sel} !== 5'b11001) begin errors++; $display("FAIL jal_wb got=%b exp=11001", {rf_we, wb_sel, pc_sel}); end
        tick();
        checks++; if (retired !== 32'd7) begin errors++; $display("FAIL jal_retired got=%0d exp=7", retired); end
    endtask

    // JALR then ECALL after a fresh reset; HALT is absorbing
    task automatic test_jalr_ecall();
        do_reset();
        opcode = 7'b1100111; mem_ready = 1'b1;
        tick(); tick(); tick(); tick(); // WRITEBACK
        checks++; if ({rf_we, wb_sel, pc_sel} !== 5'b11010) begin errors++; $display("FAIL jalr_wb got=%b exp=11010", {rf_we, wb_sel, pc_sel}); end
        tick(); // FETCH
        opcode = 7'b1110011;
        tick(); tick(); // HALT
        checks++; if ({halted, illegal} !== 2'b10) begin errors++; $display("FAIL ecall_flags got=%b exp=10", {halted, illegal}); end
        for (int i = 0; i < 20; i++) begin
            checks++; if ({mem_req, pc_we, rf_we, ir_control, halted, retired} !== {5'b00000, 1'b1, 32'd1}) begin errors++; $display("FAIL halt_hold%0d got=%b/%0d exp=000001/1", i, {mem_req, pc_we, rf_we, ir_control, halted}, retired); end
            tick();
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 7'b1111111; mem_ready = 1'b1;
        tick(); tick(); tick(); // HALT
        checks++; if ({halted, illegal, retired} !== {2'b01, 32'd0}) begin errors++; $display("FAIL illegal_flags got=%b/%0d exp=01/0", {halted, illegal}, retired); end
        tick(); tick();
        checks++; if ({illegal, mem_req, pc_we} !== 3'b100) begin errors++; $display("FAIL illegal_hold got=%b exp=100", {illegal, mem_req, pc_we}); end
    endtask

    // Reset during a stalled fetch abandons the request and restarts cleanly
    task automatic test_reset_mid_fetch();
        do_reset();
        opcode = 7'b0110011; mem_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick(); // back in FETCH, retired=1
        mem_ready = 1'b0;
        tick(); // still FETCH, waiting
        checks++; if ({mem_req, retired} !== {1'b1, 32'd1}) begin errors++; $display("FAIL mid_wait got=%b/%0d exp=1/1", mem_req, retired); end
        reset = 1'b1;
        tick(); // INIT
        checks++; if ({mem_req, ir_control, retired} !== {3'b010, 32'd0}) begin errors++; $display("FAIL mid_init got=%b/%0d exp=010/0", {mem_req, ir_control}, retired); end
        reset = 1'b0; mem_ready = 1'b1;
        tick(); // FETCH
        checks++; if ({mem_req, mem_addr_sel, ir_control} !== 4'b1001) begin errors++; $display("FAIL mid_refetch got=%b exp=1001", {mem_req, mem_addr_sel, ir_control}); end
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw();
        test_branch();
        test_sw();
        test_lui_jal();
        test_jalr_ecall();
        test_illegal();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences Fetch/Decode/Execute/Memory/Writeback for the instruction register, PC, register file, ALU and the shared unified memory port.
- Drives the 2-bit IR control (clear/load) and the memory request handshake.
- Counts retired instructions and halts on ECALL/EBREAK or an illegal opcode.

Parameters:
- PC_RESET, 32'h0000_0000, PC value the datapath loads while the controller is in INIT (pc_sel=RESET).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instr_out[6:0] from the instruction register
- branch_taken  in  1  comparator result for the current BRANCH
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  write request (STORE data phase)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_control  out  2  [1] = clear IR, [0] = load IR
- pc_we  out  1  PC write enable
- pc_sel  out  2  0 = PC+4, 1 = branch/JAL target, 2 = ALU (JALR), 3 = PC_RESET
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- alu_op  out  2  0 = add, 1 = funct decode, 2 = compare, 3 = pass B (LUI)
- halted  out  1  ECALL/EBREAK reached
- illegal  out  1  unknown opcode reached
- retired  out  CNT_W  retired-instruction count

Behaviour:
- States: INIT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Encoding comes from the shared package.
- Default outputs: every output is 0 unless a state rule below asserts it.
- Reset:
  - Any cycle with reset=1 forces the state to INIT next edge, including mid-request.
  - Reset also clears retired, halted and illegal to 0.
  - A pending memory request is abandoned; mem_req must be 0 in INIT.
- INIT (exactly one cycle):
  - ir_control=2'b10, pc_we=1, pc_sel=3.
  - Next state: FETCH.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0, held stable until mem_ready.
  - In the cycle mem_ready=1: ir_control=2'b01 (Mealy) and next state is DECODE.
  - Otherwise the FSM stays in FETCH; zero-wait memory is allowed (ready in the first cycle).
- DECODE (one cycle, IR now valid):
  - Opcode classes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
  - SYSTEM → HALT with halted set.
  - Any other opcode → HALT with illegal set.
  - All remaining classes → EXECUTE.
- EXECUTE, per opcode class:
  - OP/OP-IMM: alu_op=1.
  - LUI: alu_op=3.
  - AUIPC/LOAD/STORE/JAL/JALR: alu_op=0.
  - BRANCH: alu_op=2, pc_we=1, pc_sel = branch_taken ? 1 : 0 (Mealy). Retires; next state FETCH.
  - LOAD/STORE → MEM; all other classes → WRITEBACK.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we = (opcode==STORE); waits on mem_ready.
  - LOAD: on ready → WRITEBACK.
  - STORE: on ready, pc_we=1, pc_sel=0, retires; next state FETCH.
- WRITEBACK (one cycle):
  - rf_we=1, pc_we=1; next state FETCH; retires.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
- HALT:
  - Absorbing until reset; all enables 0; ir_control=2'b00.
  - halted/illegal stay held.
- Retired counter:
  - +1 on each retiring cycle; wraps modulo 2^CNT_W.
  - Never increments for a halting instruction.
- Invariants:
  - ir_control never equals 2'b11.
  - mem_req is never asserted outside FETCH/MEM.
  - rf_we and mem_we are never both 1.
- Cycle counts, zero-wait memory:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Package mc_pkg holds:
  - state_t enum.
  - Opcode localparams.
  - pc_sel, wb_sel and alu_op encodings.
  - IR_CLEAR = 2'b10, IR_LOAD = 2'b01.
- One sub-module: opcode_classifier (combinational, opcode → class enum plus legal flag). Everything else stays in multicycle_controller.

Test Plan:
- Reset then ADD (opcode 0110011), mem_ready always 1:
  - INIT shows ir_control=10, pc_sel=3.
  - FETCH shows ir_control=01.
  - WRITEBACK at cycle 4 shows rf_we=1, pc_sel=0.
  - retired=1.
- LW with mem_ready low for 3 cycles in FETCH and 2 in MEM:
  - mem_req/mem_addr_sel stay stable while waiting.
  - WRITEBACK has wb_sel=1, 10 cycles total, retired increments once.
- BEQ with branch_taken=1, then 0:
  - EXECUTE gives pc_we=1, pc_sel=1, then pc_sel=0.
  - No WRITEBACK state, rf_we never 1.
- SW: MEM cycle shows mem_we=1, mem_addr_sel=1, rf_we=0; PC+4 on ready.
- JALR followed by ECALL:
  - JALR WRITEBACK gives wb_sel=2, pc_sel=2.
  - ECALL → HALT, halted=1, retired stays 1, stays halted 20 cycles.
  - Opcode 1111111 instead sets illegal=1.
- Reset asserted mid-FETCH wait (mem_ready=0):
  - Next cycle is INIT with mem_req=0, retired=0.
  - Normal fetch resumes afterwards.
